// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the auto-mode playback path: note codes, FSM states
// and the one-hot note LED patterns.
package music_pkg;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;

  typedef enum logic [1:0] {
    LOAD0 = 2'd0,
    LOAD1 = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [6:0] LED_OFF = 7'b0000000;
  localparam logic [6:0] led1    = 7'b0000001;
  localparam logic [6:0] led2    = 7'b0000010;
  localparam logic [6:0] led3    = 7'b0000100;
  localparam logic [6:0] led4    = 7'b0001000;
  localparam logic [6:0] led5    = 7'b0010000;
  localparam logic [6:0] led6    = 7'b0100000;
  localparam logic [6:0] led7    = 7'b1000000;

  // Only the seven natural notes light an LED; rests and sharps stay dark.
  function automatic logic [6:0] note_led(input logic [3:0] note);
    case (note)
      4'd1:    note_led = led1;
      4'd2:    note_led = led2;
      4'd3:    note_led = led3;
      4'd4:    note_led = led4;
      4'd5:    note_led = led5;
      4'd6:    note_led = led6;
      4'd7:    note_led = led7;
      default: note_led = LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Beat-unit timer: free-running modulo-TICK_CYCLES counter with a one-cycle
// beat pulse on the terminal count.
module beat_timer #(
  parameter int TICK_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic beat
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Gated by en so a held terminal count cannot emit a second beat.
  assign beat = en && !clr && (count_r == LAST);

  // Tick counter; clear wins over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= (count_r == LAST) ? '0 : count_r + CW'(1);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Auto-mode playback controller: walks the song ROM, times each note in beats,
// inserts an articulation gap and drives the buzzer note/octave and note LEDs.
module song_sequencer
  import music_pkg::*;
#(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int SONG_LEN    = 56,
  parameter int NUM_SONGS   = 3,
  parameter int POS_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next_btn,
  input  logic             prev_btn,
  input  logic             pause,
  output logic [POS_W+1:0] rom_addr,
  input  logic [3:0]       rom_note,
  input  logic [1:0]       rom_octave,
  input  logic [3:0]       rom_dur,
  output logic [3:0]       note_to_play,
  output logic [1:0]       octave_auto,
  output logic [6:0]       led_out,
  output logic [1:0]       song_num,
  output logic             busy
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SONG_LEN - 1);
  localparam logic [1:0]       SONG_MAX = 2'(NUM_SONGS - 1);

  state_t           state_r, state_s;
  logic [POS_W-1:0] position_r, position_s;
  logic [1:0]       song_r, song_s;
  logic [3:0]       beat_cnt_r, beat_cnt_s;
  logic [GW-1:0]    gap_cnt_r, gap_cnt_s;
  logic [3:0]       dur_eff_r, dur_eff_s;
  logic [3:0]       note_lat_r, note_lat_s;
  logic [3:0]       note_r, note_s;
  logic [1:0]       oct_r, oct_s;
  logic [6:0]       led_r, led_s;
  logic             busy_r, busy_s;
  logic             next_q_r, prev_q_r;
  logic             next_rise_s, prev_rise_s, change_s;
  logic             beat_s, tmr_en_s, tmr_clr_s;

  assign next_rise_s = next_btn & ~next_q_r;
  assign prev_rise_s = prev_btn & ~prev_q_r;
  // Simultaneous next and prev edges cancel out.
  assign change_s    = next_rise_s ^ prev_rise_s;
  assign tmr_en_s    = (state_r == PLAY) && !pause;
  assign tmr_clr_s   = change_s || (state_r != PLAY);

  beat_timer #(.TICK_CYCLES(TICK_CYCLES)) u_beat_timer (
    .clk   (clk),
    .reset (reset),
    .en    (tmr_en_s),
    .clr   (tmr_clr_s),
    .beat  (beat_s)
  );

  // Next-state and next-output logic; song change outranks pause and the FSM.
  always_comb begin
    state_s    = state_r;
    position_s = position_r;
    song_s     = song_r;
    beat_cnt_s = beat_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    dur_eff_s  = dur_eff_r;
    note_lat_s = note_lat_r;
    note_s     = note_r;
    oct_s      = oct_r;
    led_s      = led_r;
    if (change_s) begin
      if (next_rise_s) begin
        song_s = (song_r == SONG_MAX) ? 2'd0 : song_r + 2'd1;
      end else begin
        song_s = (song_r == 2'd0) ? SONG_MAX : song_r - 2'd1;
      end
      position_s = '0;
      beat_cnt_s = 4'd0;
      gap_cnt_s  = '0;
      note_s     = NOTE_REST;
      led_s      = LED_OFF;
      state_s    = LOAD0;
    end else if (pause) begin
      // Silence the buzzer but keep the LEDs and all timing state frozen.
      note_s = NOTE_REST;
    end else begin
      case (state_r)
        LOAD0: state_s = LOAD1;
        LOAD1: begin
          if (rom_note == NOTE_END) begin
            position_s = '0;
            state_s    = LOAD0;
          end else begin
            note_lat_s = rom_note;
            note_s     = rom_note;
            oct_s      = rom_octave;
            led_s      = note_led(rom_note);
            dur_eff_s  = (rom_dur == 4'd0) ? 4'd1 : rom_dur;
            beat_cnt_s = 4'd0;
            state_s    = PLAY;
          end
        end
        PLAY: begin
          note_s = note_lat_r;
          if (beat_s) begin
            if (beat_cnt_r == dur_eff_r - 4'd1) begin
              beat_cnt_s = 4'd0;
              gap_cnt_s  = '0;
              note_s     = NOTE_REST;
              led_s      = LED_OFF;
              state_s    = GAP;
            end else begin
              beat_cnt_s = beat_cnt_r + 4'd1;
            end
          end else begin
            beat_cnt_s = beat_cnt_r;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_s  = '0;
            position_s = (position_r == POS_LAST) ? '0 : position_r + POS_W'(1);
            state_s    = LOAD0;
          end else begin
            gap_cnt_s = gap_cnt_r + GW'(1);
          end
        end
        default: state_s = LOAD0;
      endcase
    end
    busy_s = ((state_s == PLAY) || (state_s == GAP)) && !pause;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= LOAD0;
      position_r <= '0;
      song_r     <= 2'd0;
      beat_cnt_r <= 4'd0;
      gap_cnt_r  <= '0;
      dur_eff_r  <= 4'd0;
      note_lat_r <= NOTE_REST;
      note_r     <= NOTE_REST;
      oct_r      <= 2'd0;
      led_r      <= LED_OFF;
      busy_r     <= 1'b0;
      next_q_r   <= 1'b0;
      prev_q_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      position_r <= position_s;
      song_r     <= song_s;
      beat_cnt_r <= beat_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      dur_eff_r  <= dur_eff_s;
      note_lat_r <= note_lat_s;
      note_r     <= note_s;
      oct_r      <= oct_s;
      led_r      <= led_s;
      busy_r     <= busy_s;
      next_q_r   <= next_btn;
      prev_q_r   <= prev_btn;
    end
  end

  assign rom_addr     = {song_r, position_r};
  assign note_to_play = note_r;
  assign octave_auto  = oct_r;
  assign led_out      = led_r;
  assign song_num     = song_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small registered-read ROM model.
module tb_song_sequencer;

  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        next_btn = 1'b0;
  logic        prev_btn = 1'b0;
  logic        pause = 1'b0;
  logic [PW+1:0] rom_addr;
  logic [3:0]  rom_note;
  logic [1:0]  rom_octave;
  logic [3:0]  rom_dur;
  logic [3:0]  note_to_play;
  logic [1:0]  octave_auto;
  logic [6:0]  led_out;
  logic [1:0]  song_num;
  logic        busy;

  logic [9:0]  mem [16];   // {note, octave, dur}

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       nxt;
    logic       prv;
    logic       pse;
    logic [3:0] note;
    logic [6:0] led;
    logic [1:0] oct;
    logic [1:0] song;
  } vec_t;

  vec_t tbl[$];

  song_sequencer #(
    .TICK_CYCLES(4), .GAP_CYCLES(2), .SONG_LEN(4), .NUM_SONGS(3), .POS_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .next_btn(next_btn), .prev_btn(prev_btn),
    .pause(pause), .rom_addr(rom_addr), .rom_note(rom_note),
    .rom_octave(rom_octave), .rom_dur(rom_dur), .note_to_play(note_to_play),
    .octave_auto(octave_auto), .led_out(led_out), .song_num(song_num), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) {rom_note, rom_octave, rom_dur} <= mem[rom_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; next_btn = 1'b0; prev_btn = 1'b0; pause = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input int n, input logic [3:0] note, input logic [6:0] led, input logic [1:0] oct);
    vec_t v;
    v.nxt = 1'b0; v.prv = 1'b0; v.pse = 1'b0;
    v.note = note; v.led = led; v.oct = oct; v.song = 2'd0;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      next_btn = tbl[i].nxt; prev_btn = tbl[i].prv; pause = tbl[i].pse;
      step();
      checks++;
      if (note_to_play !== tbl[i].note || led_out !== tbl[i].led ||
          octave_auto !== tbl[i].oct || song_num !== tbl[i].song) begin
        errors++;
        $display("FAIL %s row %0d: got note=%0h led=%b oct=%0d song=%0d expected note=%0h led=%b oct=%0d song=%0d",
                 name, i, note_to_play, led_out, octave_auto, song_num,
                 tbl[i].note, tbl[i].led, tbl[i].oct, tbl[i].song);
      end
    end
    tbl.delete();
  endtask

  task automatic load_default_rom();
    mem[0] = {4'd1, 2'd1, 4'd2};
    mem[1] = {4'd3, 2'd2, 4'd1};
    mem[2] = {4'd0, 2'd0, 4'd1};
    mem[3] = {4'd5, 2'd0, 4'd1};
    for (int i = 4; i < 8; i++)   mem[i] = {4'd2, 2'd1, 4'd1};
    for (int i = 8; i < 12; i++)  mem[i] = {4'd7, 2'd3, 4'd1};
    for (int i = 12; i < 16; i++) mem[i] = 10'd0;
  endtask

  int on_cnt;

  initial begin
    load_default_rom();
    #12;
    check("reset note", 32'(note_to_play), 32'd0);
    check("reset led", 32'(led_out), 32'd0);
    check("reset song", 32'(song_num), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset addr", 32'(rom_addr), 32'd0);
    check("reset oct", 32'(octave_auto), 32'd0);

    // Full pass through song 0 with wrap back to position 0.
    do_reset();
    add(1, 4'd0, 7'b0000000, 2'd0);
    add(8, 4'd1, 7'b0000001, 2'd1);
    add(4, 4'd0, 7'b0000000, 2'd1);
    add(4, 4'd3, 7'b0000100, 2'd2);
    add(4, 4'd0, 7'b0000000, 2'd2);
    add(4, 4'd0, 7'b0000000, 2'd0);
    add(4, 4'd0, 7'b0000000, 2'd0);
    add(4, 4'd5, 7'b0010000, 2'd0);
    add(4, 4'd0, 7'b0000000, 2'd0);
    add(8, 4'd1, 7'b0000001, 2'd1);
    run_table("song0");

    // Zero duration plays one beat; end marker at position 1 loops to 0.
    mem[0] = {4'd1, 2'd1, 4'd0};
    mem[1] = {4'hF, 2'd0, 4'd1};
    do_reset();
    add(1, 4'd0, 7'b0000000, 2'd0);
    add(4, 4'd1, 7'b0000001, 2'd1);
    add(6, 4'd0, 7'b0000000, 2'd1);
    add(4, 4'd1, 7'b0000001, 2'd1);
    add(1, 4'd0, 7'b0000000, 2'd1);
    run_table("dur0_end");

    // Pause for 5 cycles after the first beat of a 2-beat note.
    load_default_rom();
    do_reset();
    on_cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (note_to_play != 4'd0) on_cnt++;
    end
    check("pre-pause note", 32'(note_to_play), 32'd1);
    pause = 1'b1;
    step();
    if (note_to_play != 4'd0) on_cnt++;
    check("pause note off", 32'(note_to_play), 32'd0);
    check("pause led hold", 32'(led_out), 32'h01);
    step();
    if (note_to_play != 4'd0) on_cnt++;
    check("pause busy", 32'(busy), 32'd0);
    for (int e = 9; e <= 11; e++) begin
      step();
      if (note_to_play != 4'd0) on_cnt++;
    end
    pause = 1'b0;
    step();
    if (note_to_play != 4'd0) on_cnt++;
    check("resume note", 32'(note_to_play), 32'd1);
    check("resume busy", 32'(busy), 32'd1);
    for (int e = 13; e <= 18; e++) begin
      step();
      if (note_to_play != 4'd0) on_cnt++;
    end
    check("pause total on", 32'(on_cnt), 32'd8);
    step();
    check("after pause next note", 32'(note_to_play), 32'd3);

    // Song selection: level hold, wrap both ways, simultaneous edges, change while paused.
    do_reset();
    repeat (4) step();
    check("song seq start", 32'(note_to_play), 32'd1);
    next_btn = 1'b1;
    step();
    check("next song", 32'(song_num), 32'd1);
    check("next note off", 32'(note_to_play), 32'd0);
    check("next led off", 32'(led_out), 32'd0);
    check("next addr", 32'(rom_addr), 32'h4);
    step();
    step();
    check("held next no repeat", 32'(song_num), 32'd1);
    check("song1 note", 32'(note_to_play), 32'd2);
    next_btn = 1'b0;
    step();
    next_btn = 1'b1;
    step();
    check("next to 2", 32'(song_num), 32'd2);
    next_btn = 1'b0;
    step();
    next_btn = 1'b1;
    step();
    check("next wrap", 32'(song_num), 32'd0);
    check("wrap note off", 32'(note_to_play), 32'd0);
    next_btn = 1'b0;
    step();
    step();
    check("restart pos0", 32'(note_to_play), 32'd1);
    prev_btn = 1'b1;
    step();
    check("prev wrap", 32'(song_num), 32'd2);
    prev_btn = 1'b0;
    step();
    next_btn = 1'b1; prev_btn = 1'b1;
    step();
    check("both ignored song", 32'(song_num), 32'd2);
    check("both ignored note", 32'(note_to_play), 32'd7);
    check("song2 led", 32'(led_out), 32'h40);
    next_btn = 1'b0; prev_btn = 1'b0;
    step();
    check("both ignored later", 32'(song_num), 32'd2);
    pause = 1'b1;
    step();
    check("pause in song2", 32'(note_to_play), 32'd0);
    next_btn = 1'b1;
    step();
    check("change while paused", 32'(song_num), 32'd0);
    next_btn = 1'b0;
    repeat (3) step();
    check("paused hold note", 32'(note_to_play), 32'd0);
    check("paused hold busy", 32'(busy), 32'd0);
    check("paused hold addr", 32'(rom_addr), 32'd0);
    pause = 1'b0;
    step();
    check("release load1", 32'(note_to_play), 32'd0);
    step();
    check("release play", 32'(note_to_play), 32'd1);

    // Asynchronous reset in the middle of a note.
    #1;
    reset = 1'b1;
    #1;
    check("async note", 32'(note_to_play), 32'd0);
    check("async led", 32'(led_out), 32'd0);
    check("async oct", 32'(octave_auto), 32'd0);
    check("async busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
